// File: rtl/rim_pkg.sv
// Shared definitions for the rat-in-maze path-map stage: sizes, FSM states,
// the start/goal coordinates and a column-to-bitmap-mask helper.
package rim_pkg;

  localparam int N       = 8;
  localparam int COORD_W = 3;
  localparam int LEN_W   = 7;

  localparam logic [LEN_W-1:0] LEN_MAX = 7'd64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } rim_map_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } rim_coord_t;

  localparam rim_coord_t RIM_START = '{row: 3'd0, col: 3'd0};
  localparam rim_coord_t RIM_GOAL  = '{row: 3'd7, col: 3'd7};

  // Column 0 lives in the MSB of a row, matching the solver's maze rows.
  function automatic logic [N-1:0] rim_col_mask(input logic [COORD_W-1:0] col);
    rim_col_mask = {1'b1, {(N-1){1'b0}}} >> col;
  endfunction

endpackage

// File: rtl/rim_step_check.sv
// Combinational legality check for one path step: the new coordinate must be
// exactly one orthogonal move from the previous one and must not revisit a
// cell already on the path.
module rim_step_check
  import rim_pkg::*;
(
  input  logic [COORD_W-1:0] i_prev_row,
  input  logic [COORD_W-1:0] i_prev_col,
  input  logic [COORD_W-1:0] i_cur_row,
  input  logic [COORD_W-1:0] i_cur_col,
  input  logic               i_bit,
  output logic               o_adj_ok,
  output logic               o_revisit
);

  logic signed [3:0] w_drow;
  logic signed [3:0] w_dcol;
  logic        [3:0] w_abs_row;
  logic        [3:0] w_abs_col;
  logic        [4:0] w_dist;

  assign w_drow    = $signed({1'b0, i_cur_row}) - $signed({1'b0, i_prev_row});
  assign w_dcol    = $signed({1'b0, i_cur_col}) - $signed({1'b0, i_prev_col});
  assign w_abs_row = w_drow[3] ? $unsigned(-w_drow) : $unsigned(w_drow);
  assign w_abs_col = w_dcol[3] ? $unsigned(-w_dcol) : $unsigned(w_dcol);
  assign w_dist    = {1'b0, w_abs_row} + {1'b0, w_abs_col};

  assign o_adj_ok  = (w_dist == 5'd1);
  assign o_revisit = i_bit;

endmodule

// File: rtl/rim_path_map.sv
// Path-map stage: gathers the solver's (row,col) step stream into an 8x8
// bitmap, counts steps (saturating at 64), flags illegal paths and then
// streams the bitmap out one row per valid/ready beat.
// Optional feature macro: RIM_PATH_CHECK_EN enables the per-step adjacency
// and revisit checks; without it err covers only start and early-end.
module rim_path_map
  import rim_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [COORD_W-1:0] in_row,
  input  logic [COORD_W-1:0] in_col,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [COORD_W-1:0] out_idx,
  output logic [N-1:0]       out_map,
  output logic [LEN_W-1:0]   path_len,
  output logic               err
);

  rim_map_state_t r_state;
  rim_map_state_t w_state_next;

  logic [N-1:0][N-1:0] r_bitmap;
  logic [N-1:0][N-1:0] w_bitmap_next;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    w_len_next;
  logic                r_err;
  logic                w_err_next;
  logic                r_out_valid;
  logic                w_out_valid_next;
  logic [COORD_W-1:0]  r_out_idx;
  logic [COORD_W-1:0]  w_out_idx_next;
  logic [COORD_W-1:0]  w_idx_inc;
  logic [N-1:0]        r_out_map;
  logic [N-1:0]        w_out_map_next;

  rim_coord_t          w_cur;
  logic [N-1:0]        w_mask;
  logic                w_is_goal;
  logic                w_is_start;
  logic                w_accept;
  logic                w_step_err;

  assign w_cur      = {in_row, in_col};
  assign w_mask     = rim_col_mask(in_col);
  assign w_is_goal  = (w_cur == RIM_GOAL);
  assign w_is_start = (w_cur == RIM_START);
  assign w_accept   = r_out_valid && out_ready;
  assign w_idx_inc  = r_out_idx + 3'd1;

`ifdef RIM_PATH_CHECK_EN
  rim_coord_t r_prev;
  logic       w_bit_hit;
  logic       w_adj_ok;
  logic       w_revisit;

  assign w_bit_hit = |(r_bitmap[in_row] & w_mask);

  rim_step_check u_step_check (
    .i_prev_row (r_prev.row),
    .i_prev_col (r_prev.col),
    .i_cur_row  (in_row),
    .i_cur_col  (in_col),
    .i_bit      (w_bit_hit),
    .o_adj_ok   (w_adj_ok),
    .o_revisit  (w_revisit)
  );

  assign w_step_err = !w_adj_ok || w_revisit;

  // Remember each accepted coordinate as the reference for the next step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= RIM_START;
    end else if (in_valid && (r_state != EMIT)) begin
      r_prev <= w_cur;
    end
  end
`else
  assign w_step_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: goal beat or a gap in the stream ends collection.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_next = w_is_goal ? EMIT : COLLECT;
        end
      end
      COLLECT: begin
        if (!in_valid || w_is_goal) begin
          w_state_next = EMIT;
        end
      end
      EMIT: begin
        if (w_accept && (r_out_idx == 3'd7)) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath and output next values; EMIT spends its first cycle loading row 0.
  always_comb begin
    w_bitmap_next    = r_bitmap;
    w_len_next       = r_len;
    w_err_next       = r_err;
    w_out_valid_next = r_out_valid;
    w_out_idx_next   = r_out_idx;
    w_out_map_next   = r_out_map;
    case (r_state)
      IDLE: begin
        w_bitmap_next    = '0;
        w_len_next       = '0;
        w_err_next       = 1'b0;
        w_out_valid_next = 1'b0;
        w_out_idx_next   = '0;
        w_out_map_next   = '0;
        if (in_valid) begin
          w_bitmap_next[in_row] = w_mask;
          w_len_next            = 7'd1;
          w_err_next            = !w_is_start;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          w_bitmap_next[in_row] = r_bitmap[in_row] | w_mask;
          w_len_next            = (r_len == LEN_MAX) ? LEN_MAX : r_len + 7'd1;
          if (w_step_err) begin
            w_err_next = 1'b1;
          end
        end else begin
          w_err_next = 1'b1;
        end
      end
      EMIT: begin
        if (!r_out_valid) begin
          w_out_valid_next = 1'b1;
          w_out_idx_next   = '0;
          w_out_map_next   = r_bitmap[0];
        end else if (out_ready) begin
          if (r_out_idx == 3'd7) begin
            w_bitmap_next    = '0;
            w_len_next       = '0;
            w_err_next       = 1'b0;
            w_out_valid_next = 1'b0;
            w_out_idx_next   = '0;
            w_out_map_next   = '0;
          end else begin
            w_out_idx_next = w_idx_inc;
            w_out_map_next = r_bitmap[w_idx_inc];
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitmap    <= '0;
      r_len       <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_map   <= '0;
    end else begin
      r_bitmap    <= w_bitmap_next;
      r_len       <= w_len_next;
      r_err       <= w_err_next;
      r_out_valid <= w_out_valid_next;
      r_out_idx   <= w_out_idx_next;
      r_out_map   <= w_out_map_next;
    end
  end

  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_map   = r_out_map;
  assign path_len  = r_len;
  assign err       = r_err;

endmodule

// File: tb/tb_rim_path_map.sv
// Bench for rim_path_map: directed paths plus random walks, each compared
// against a cell-grid model of the path rules.
module tb_rim_path_map;

`ifdef RIM_PATH_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_row;
  logic [2:0] in_col;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] out_map;
  logic [6:0] path_len;
  logic       err;

  int totalChecks = 0;
  int badChecks   = 0;

  int pathRows[$];
  int pathCols[$];
  int expMap[8];
  int expLen;
  int expErr;
  bit modelGoal;

  rim_path_map dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_row    (in_row),
    .in_col    (in_col),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_map   (out_map),
    .path_len  (path_len),
    .err       (err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int absInt(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Walk the path on an 8x8 grid of cells, stopping at the goal cell.
  function automatic void computeModel();
    bit cells[8][8];
    int len;
    bit e;
    int pr;
    int pc;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) cells[r][c] = 1'b0;
    len = 0;
    e = 1'b0;
    pr = 0;
    pc = 0;
    modelGoal = 1'b0;
    for (int i = 0; i < pathRows.size(); i++) begin
      int r;
      int c;
      r = pathRows[i];
      c = pathCols[i];
      if (i == 0) begin
        if (r != 0 || c != 0) e = 1'b1;
      end else begin
        bit stepBad;
        stepBad = (absInt(r - pr) + absInt(c - pc) != 1) || cells[r][c];
        if (CHECK_EN && stepBad) e = 1'b1;
      end
      cells[r][c] = 1'b1;
      len = (len < 64) ? len + 1 : 64;
      pr = r;
      pc = c;
      if (r == 7 && c == 7) begin
        modelGoal = 1'b1;
        break;
      end
    end
    if (!modelGoal) e = 1'b1;
    for (int r = 0; r < 8; r++) begin
      expMap[r] = 0;
      for (int c = 0; c < 8; c++)
        if (cells[r][c]) expMap[r] += (1 << (7 - c));
    end
    expLen = len;
    expErr = e;
  endfunction

  function automatic void addStep(input int r, input int c);
    pathRows.push_back(r);
    pathCols.push_back(c);
  endfunction

  task automatic drivePath();
    for (int i = 0; i < pathRows.size(); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_row   = 3'(pathRows[i]);
      in_col   = 3'(pathCols[i]);
    end
    if (!modelGoal) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // readyMode: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
  task automatic applyStimulus(input int readyMode, input bit junk);
    int accepts;
    int iter;
    int firstValid;
    int patt;
    bit go;
    computeModel();
    drivePath();
    accepts = 0;
    iter = 0;
    firstValid = -1;
    patt = 0;
    while (accepts < 8 && iter < 300) begin
      @(negedge clk);
      if (out_valid) begin
        if (firstValid < 0) begin
          firstValid = iter;
          checkOutput("latency", iter, 1);
        end
        checkOutput("out_idx", out_idx, accepts);
        checkOutput("out_map", out_map, expMap[accepts]);
        checkOutput("path_len", path_len, expLen);
        checkOutput("err", err, expErr);
        case (readyMode)
          0: go = 1'b1;
          1: go = ((patt % 4) == 0) || ((patt % 4) == 3);
          default: go = 1'($urandom);
        endcase
        patt++;
        if (go) accepts++;
      end else begin
        if (firstValid >= 0) checkOutput("valid_drop", out_valid, 1);
        go = 1'($urandom);
      end
      out_ready = go;
      in_valid  = junk ? 1'($urandom) : 1'b0;
      in_row    = 3'($urandom);
      in_col    = 3'($urandom);
      iter++;
    end
    checkOutput("emit_accepts", accepts, 8);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("idle_valid", out_valid, 0);
    checkOutput("idle_len", path_len, 0);
  endtask

  function automatic void setSolverPath();
    pathRows.delete();
    pathCols.delete();
    addStep(0,0); addStep(1,0); addStep(1,1); addStep(1,2); addStep(1,3);
    addStep(2,3); addStep(3,3); addStep(3,4); addStep(4,4); addStep(4,5);
    addStep(5,5); addStep(5,6); addStep(6,6); addStep(7,6); addStep(7,7);
  endfunction

  function automatic void genRandomPath();
    int r;
    int c;
    int len;
    pathRows.delete();
    pathCols.delete();
    r = 0;
    c = 0;
    if ($urandom_range(0, 7) == 0) begin
      r = $urandom_range(0, 7);
      c = $urandom_range(0, 7);
    end
    len = $urandom_range(1, 70);
    for (int k = 0; k < len; k++) begin
      addStep(r, c);
      if (r == 7 && c == 7) break;
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 7);
        c = $urandom_range(0, 7);
      end else begin
        case ($urandom_range(0, 3))
          0: r = (r < 7) ? r + 1 : r;
          1: r = (r > 0) ? r - 1 : r;
          2: c = (c < 7) ? c + 1 : c;
          default: c = (c > 0) ? c - 1 : c;
        endcase
      end
    end
    if (!(pathRows[$] == 7 && pathCols[$] == 7) && $urandom_range(0, 1) == 1)
      addStep(7, 7);
  endfunction

  task automatic resetDuringEmit();
    int iter;
    bit hit;
    setSolverPath();
    computeModel();
    drivePath();
    iter = 0;
    hit = 1'b0;
    while (!hit && iter < 100) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (out_valid && out_idx == 3'd3) hit = 1'b1;
      iter++;
    end
    checkOutput("reach_row3", hit, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_idx", out_idx, 0);
    checkOutput("rst_map", out_map, 0);
    checkOutput("rst_len", path_len, 0);
    checkOutput("rst_err", err, 0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Main sequence: reset, directed paths, then random walks.
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_row    = '0;
    in_col    = '0;
    out_ready = 1'b0;
    #1;
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_idx", out_idx, 0);
    checkOutput("reset_map", out_map, 0);
    checkOutput("reset_len", path_len, 0);
    checkOutput("reset_err", err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    setSolverPath();
    applyStimulus(0, 1'b0);
    setSolverPath();
    applyStimulus(1, 1'b1);

    pathRows.delete();
    pathCols.delete();
    addStep(0, 0);
    addStep(1, 0);
    applyStimulus(0, 1'b0);

    pathRows.delete();
    pathCols.delete();
    for (int i = 0; i < 8; i++) addStep(i, i);
    applyStimulus(2, 1'b1);

    pathRows.delete();
    pathCols.delete();
    for (int i = 0; i < 70; i++) addStep(i % 2, 0);
    addStep(7, 7);
    applyStimulus(0, 1'b0);

    pathRows.delete();
    pathCols.delete();
    addStep(7, 7);
    applyStimulus(2, 1'b0);

    resetDuringEmit();
    setSolverPath();
    applyStimulus(0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      genRandomPath();
      applyStimulus(2, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/rim_path_map.md
# rim_path_map

Downstream consumer of the rat-in-maze solver's coordinate stream. Collects the stream of `(row, col)` path steps into an 8×8 path bitmap and counts the steps. When checking is compiled in, it also flags illegal paths. It then emits the bitmap one row per beat to the next stage under a valid/ready handshake. Row bit convention matches the solver's maze input: bit 7 is column 0.

## Interface
- `N`, 8, maze dimension (rows = columns); fixed at 8 for this revision.
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `rst_n`, input, 1, asynchronous, active-low reset.
- `in_valid`, input, 1, qualifies `in_row`/`in_col`; driven directly by the solver's `out_valid`.
- `in_row`, input, 3, path step row (solver `out_row`).
- `in_col`, input, 3, path step column (solver `out_col`).
- `out_ready`, input, 1, downstream accepts the current row.
- `out_valid`, output, 1, `out_map`/`out_idx` valid.
- `out_idx`, output, 3, index of the row currently presented (0..7).
- `out_map`, output, 8, path bitmap row; bit `7-c` is set if column `c` of that row is on the path.
- `path_len`, output, 7, number of accepted steps (1..64); stable while `out_valid`=1.
- `err`, output, 1, path illegal; stable while `out_valid`=1.

## Operation
- States: IDLE, COLLECT, EMIT.
- IDLE
  - Bitmap, `path_len` and `err` are cleared.
  - First `in_valid` beat: set the bitmap bit, `path_len`=1, go to COLLECT.
  - Set `err` if that first coordinate ≠ (0,0).
  - If that first coordinate is (7,7), go directly to EMIT instead.
- COLLECT, each `in_valid` beat
  - Set the bitmap bit.
  - `path_len`+1, saturating at 64.
  - Remember the coordinate as the previous step.
- COLLECT exits to EMIT when either:
  - a beat carries (7,7) (normal end), or
  - `in_valid` is low for one cycle (stream ended early); `err` is set in this case.
- EMIT
  - `out_valid`=1 and `out_idx` starts at 0.
  - `out_map` = bitmap row `out_idx`.
  - When `out_valid`&&`out_ready`: `out_idx`+1.
  - On acceptance of row 7: go to IDLE, clear all state.
  - `in_valid` beats in EMIT are dropped; they do not start a new path.
- Step checks (only with the configuration macro):
  - `err` is set if `|Δrow|+|Δcol|` ≠ 1 versus the previous step.
  - `err` is set if the target bit is already set (revisit).
  - `err` is sticky until return to IDLE.
- Arithmetic
  - Δ is computed on 4-bit signed differences.
  - `path_len` is 7 bits; the 65th and later beats do not wrap it.

## Timing
- Reset values: `out_valid`=0, `out_idx`=0, `out_map`=0, `path_len`=0, `err`=0, state IDLE, bitmap all zero.
- All outputs are registered.
- Latency:
  - (7,7) beat sampled at edge t → `out_valid`=1 after edge t+1.
  - First low `in_valid` cycle in COLLECT sampled at edge t → `out_valid`=1 after edge t+1.
- Handshake:
  - `out_valid` never drops without acceptance.
  - `out_map`/`out_idx` hold while `out_ready`=0.
  - One row per accepted cycle, so minimum EMIT length is 8 cycles.
- With `out_ready` held at 1: IDLE is re-entered after the edge that accepts row 7, and a new first beat is accepted on the following edge.
- Reset asserted mid-COLLECT or mid-EMIT: all state and outputs go immediately to reset values, and the partial path is discarded.

## Configuration
- `RIM_PATH_CHECK_EN` defined:
  - The adjacency and revisit checks above are active.
  - `err` reflects the start-coordinate, early-end and step checks.
- Not defined:
  - No step-check logic is built.
  - `err` reports only the start-coordinate and early-end conditions.
  - Bitmap and `path_len` behaviour is unchanged.

## Structure
- Shared package `rim_pkg` holds:
  - `N`, coordinate width (3), `path_len` width (7);
  - state enum `rim_map_state_t` {IDLE, COLLECT, EMIT};
  - constants `RIM_START` = (0,0) and `RIM_GOAL` = (7,7).
- One sub-module, `rim_step_check`, is natural:
  - combinational;
  - inputs: previous coordinate, current coordinate, bitmap bit;
  - outputs: `adj_ok` and `revisit`;
  - instantiated only under `RIM_PATH_CHECK_EN`.

## Test plan
- Solver maze path, consecutive beats (0,0),(1,0),(1,1),(1,2),(1,3),(2,3),(3,3),(3,4),(4,4),(4,5),(5,5),(5,6),(6,6),(7,6),(7,7), with `out_ready`=1 → rows 0x80,0xF0,0x10,0x18,0x0C,0x06,0x02,0x03, `path_len`=15, `err`=0.
- Same path with `out_ready` toggling 1,0,0,1,… → every row is held while stalled, no row is skipped or duplicated, and exactly 8 accepts occur.
- Stream (0,0),(1,0), then `in_valid` low → rows 0x80,0x80,0x00×6, `path_len`=2, `err`=1.
- With `RIM_PATH_CHECK_EN`: (0,0),(1,1),…,(7,7) diagonal (non-adjacent) → `err`=1, `path_len`=8, bitmap shows the diagonal 0x80,0x40,…,0x01. Without the macro → `err`=0.
- With `RIM_PATH_CHECK_EN`: (0,0),(1,0),(0,0),(1,0),… revisits → `err`=1; 70 alternating beats before (7,7) → `path_len`=64 (saturated).
- Assert `rst_n` during EMIT at row 3 → `out_valid`=0 immediately; the next clean path emits starting at `out_idx`=0.
